// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the byte-stream instruction loader.
package instr_loader_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/word_packer.sv
// Assembles little-endian bytes into one instruction word; flags the fourth byte.
module word_packer
  import instr_loader_pkg::*;
#(
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   load,
  input  logic [7:0]             byte_data,
  output logic [INSTR_WIDTH-1:0] word,
  output logic                   word_full
);

  localparam int IDX_W = $clog2(BYTES_PER_WORD);

  logic [IDX_W-1:0] byte_index;

  // High on the transfer that completes the word, so the FSM can leave RECV on that edge.
  assign word_full = load && (byte_index == IDX_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_index <= '0;
      word       <= '0;
    end else if (clear) begin
      byte_index <= '0;
      word       <= '0;
    end else if (load) begin
      word[8*byte_index +: 8] <= byte_data;
      byte_index              <= byte_index + 1'b1;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Loads a program from a byte stream into instruction memory, holding the CPU in reset meanwhile.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int MAX_WORDS   = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  word_count,
  input  logic                   byte_valid,
  input  logic [7:0]             byte_data,
  output logic                   byte_ready,
  output logic                   wr_en,
  output logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic [INSTR_WIDTH-1:0] wr_data,
  output logic                   busy,
  output logic                   cpu_rst,
  output logic                   done,
  output logic                   error
);

  localparam logic [ADDR_WIDTH-1:0] MAX_WC = ADDR_WIDTH'(MAX_WORDS);

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   count_q;
  logic [ADDR_WIDTH-3:0]   word_index;
  logic                    error_q;
  logic                    start_ok;
  logic                    pk_clear;
  logic                    pk_load;
  logic                    word_full;
  logic                    last_word;

  assign start_ok  = start && (word_count != '0) && (word_count <= MAX_WC);
  assign pk_clear  = (state == ST_IDLE) && start_ok;
  assign pk_load   = (state == ST_RECV) && byte_valid;
  assign last_word = (({2'b00, word_index} + ADDR_WIDTH'(1)) == count_q);

  word_packer #(
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (pk_clear),
    .load      (pk_load),
    .byte_data (byte_data),
    .word      (wr_data),
    .word_full (word_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      count_q    <= '0;
      word_index <= '0;
      error_q    <= 1'b0;
    end else begin
      error_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (word_count == '0) begin
              state <= ST_DONE;
            end else if (word_count > MAX_WC) begin
              error_q <= 1'b1;
            end else begin
              count_q    <= word_count;
              word_index <= '0;
              state      <= ST_RECV;
            end
          end
        end
        ST_RECV: begin
          if (word_full) state <= ST_WRITE;
        end
        ST_WRITE: begin
          if (last_word) begin
            state <= ST_DONE;
          end else begin
            word_index <= word_index + 1'b1;
            state      <= ST_RECV;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Control outputs decode directly from state so reset clears them without waiting for a clock.
  assign byte_ready = (state == ST_RECV);
  assign wr_en      = (state == ST_WRITE);
  assign wr_addr    = {word_index, 2'b00};
  assign busy       = (state != ST_IDLE);
  assign cpu_rst    = (state != ST_IDLE);
  assign done       = (state == ST_DONE);
  assign error      = error_q;

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, width of write address and word_count.
REQ-002 Parameter INSTR_WIDTH, default 32, instruction word width; fixed at 32 (4 bytes).
REQ-003 Parameter MAX_WORDS, default 256, instruction memory capacity in words.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  single-cycle request to begin a load.
REQ-007 word_count  input  ADDR_WIDTH  number of words to load; sampled only when start is accepted.
REQ-008 byte_valid  input  1  source presents byte_data.
REQ-009 byte_data  input  8  program byte stream, little-endian within each word.
REQ-010 byte_ready  output  1  loader accepts a byte this cycle.
REQ-011 wr_en  output  1  instruction memory write strobe.
REQ-012 wr_addr  output  ADDR_WIDTH  byte address of the written word (word_index << 2).
REQ-013 wr_data  output  INSTR_WIDTH  assembled instruction word.
REQ-014 busy  output  1  load in progress.
REQ-015 cpu_rst  output  1  holds the CPU in reset while busy.
REQ-016 done  output  1  one-cycle pulse on successful load completion.
REQ-017 error  output  1  one-cycle pulse when a start is rejected.

Function
REQ-018 States IDLE, RECV, WRITE, DONE; busy = cpu_rst = (state != IDLE).
REQ-019 IDLE: byte_ready = 0; byte_valid is ignored; start with 0 < word_count <= MAX_WORDS latches word_count, clears word_index and byte_index, and goes to RECV.
REQ-020 Start with word_count == 0: go to DONE; no writes.
REQ-021 Start with word_count > MAX_WORDS: error = 1 the next cycle; state stays IDLE.
REQ-022 start while busy is ignored, with no effect on any state or output.
REQ-023 RECV: byte_ready = 1; a byte transfers only when byte_valid && byte_ready at a rising edge.
REQ-024 A transferred byte is stored in lane byte_index (bits 8*i+7:8*i); byte_index increments modulo 4.
REQ-025 The fourth byte transfer moves to WRITE; wr_en = 1 for exactly that one cycle, with wr_data = assembled word and wr_addr = word_index << 2.
REQ-026 WRITE: byte_ready = 0; the source's stalled byte is held, not dropped.
REQ-027 After WRITE: if word_index + 1 == latched word_count, go to DONE; otherwise increment word_index and return to RECV.
REQ-028 DONE: done = 1 for one cycle, then IDLE; cpu_rst deasserts in the first IDLE cycle.
REQ-029 byte_valid gaps in RECV stall the loader indefinitely with no timeout; partial-word state is retained.
REQ-030 wr_en is 0 in every state except WRITE; wr_addr never exceeds (MAX_WORDS-1) << 2.

Reset
REQ-031 When rst_n is low, immediately go to IDLE and set all outputs to 0: byte_ready, wr_en, wr_addr, wr_data, busy, cpu_rst, done, error.
REQ-032 Reset mid-load discards the partial word and counters; no write occurs after reset asserts; memory contents already written are untouched.

Structure
REQ-033 Package instr_loader_pkg holds the state enum typedef and the BYTES_PER_WORD = 4 constant.
REQ-034 Sub-module word_packer handles byte-lane assembly and byte_index, with load/clear inputs and word_full output; the FSM and address counter live in instr_loader.

Verification
REQ-035 start, word_count=2, bytes 13,00,00,00,93,00,10,00 back-to-back -> wr_en at addr 0x0 data 0x00000013, then addr 0x4 data 0x00100093; done one cycle later.
REQ-036 Same load with byte_valid low 3 cycles between every byte -> identical writes; busy and cpu_rst high throughout; no extra wr_en.
REQ-037 start with word_count=0 -> done pulse 1 cycle after start, zero wr_en pulses; start with word_count=MAX_WORDS+1 -> error pulse, busy stays 0.
REQ-038 rst_n low after 2 bytes of word 1 -> all outputs 0 immediately, no write; a fresh start then loads from addr 0x0 correctly.
REQ-039 byte_valid held high during WRITE cycle -> byte_ready 0 that cycle; the held byte is taken as lane 0 of the next word.
REQ-040 start pulsed during RECV with a different word_count -> ignored; the load completes with the originally latched count.
